// File: rtl/sbox_share_if.sv
// Handshake and data bundle between the AES round/key logic and the shared S-box scheduler.
// The slave side is the scheduler; the master side is the requester pair.
interface sbox_share_if;
  logic           st_valid;
  logic           st_ready;
  logic [0:127]   st_in;
  logic           st_done;
  logic [0:127]   st_out;
  logic           wd_valid;
  logic           wd_ready;
  logic [0:31]    wd_in;
  logic           wd_done;
  logic [0:31]    wd_out;
  logic           busy;

  modport master (
    output st_valid, st_in, wd_valid, wd_in,
    input  st_ready, st_done, st_out, wd_ready, wd_done, wd_out, busy
  );

  modport slave (
    input  st_valid, st_in, wd_valid, wd_in,
    output st_ready, st_done, st_out, wd_ready, wd_done, wd_out, busy
  );
endinterface

// File: rtl/sbox_share_ctrl.sv
// Four-instance S-box bank shared between a 4-beat state SubBytes and a 1-cycle SubWord.
// Define SBOX_SHARE_RR_EN for round-robin tie-breaking; otherwise the word always wins ties.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[{a, 3'b000} +: 8];
endmodule

module sbox_share_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  sbox_share_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_BEAT = 2'd1,
    WORD    = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   beat;
  logic [0:127] st_reg;
  logic [0:31]  wd_reg;
  logic [0:31]  bank_in;
  logic [0:31]  bank_out;
  logic         word_pri;
  logic         st_acc;
  logic         wd_acc;

  assign st_acc = bus.st_valid & bus.st_ready;
  assign wd_acc = bus.wd_valid & bus.wd_ready;

`ifdef SBOX_SHARE_RR_EN
  logic last_grant_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_wd <= 1'b0;
    end else if (wd_acc) begin
      last_grant_wd <= 1'b1;
    end else if (st_acc) begin
      last_grant_wd <= 1'b0;
    end
  end

  assign word_pri = ~last_grant_wd;
`else
  assign word_pri = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wd_acc) begin
          state_nxt = WORD;
        end else if (st_acc) begin
          state_nxt = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (beat == 2'd3) begin
          state_nxt = IDLE;
        end
      end
      WORD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A ready looks only at the other side's valid, never its own.
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.st_ready = 1'b0;
    bus.wd_ready = 1'b0;
    bank_in      = wd_reg;
    case (state)
      IDLE: begin
        bus.st_ready = ~(bus.wd_valid & word_pri);
        bus.wd_ready = ~(bus.st_valid & ~word_pri);
      end
      ST_BEAT: bank_in = st_reg[{beat, 5'b00000} +: 32];
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_bank
    sbox u_sbox (
      .a (bank_in[8*i +: 8]),
      .y (bank_out[8*i +: 8])
    );
  end

  // Capture registers are cleared as well so an aborted request leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat        <= 2'd0;
      st_reg      <= '0;
      wd_reg      <= '0;
      bus.st_out  <= '0;
      bus.wd_out  <= '0;
      bus.st_done <= 1'b0;
      bus.wd_done <= 1'b0;
    end else begin
      bus.st_done <= (state == ST_BEAT) && (beat == 2'd3);
      bus.wd_done <= (state == WORD);
      if (st_acc) begin
        st_reg <= bus.st_in;
      end
      if (wd_acc) begin
        wd_reg <= bus.wd_in;
      end
      if (state == ST_BEAT) begin
        bus.st_out[{beat, 5'b00000} +: 32] <= bank_out;
        beat <= beat + 2'd1;
      end else begin
        beat <= 2'd0;
      end
      if (state == WORD) begin
        bus.wd_out <= bank_out;
      end
    end
  end
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Scoreboard bench for sbox_share_ctrl: a GF(2^8) reference S-box predicts every result at accept time.
module tb_sbox_share_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sbox_share_if bus ();

  sbox_share_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv;
    inv = '0;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:31] sub_word(input logic [0:31] w);
    logic [0:31] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_m(w[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [0:127] sub_state(input logic [0:127] s);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_m(s[8*i +: 8]);
    return r;
  endfunction

  typedef struct {
    logic [0:127] data;
    int           cyc;
  } exp_t;

  exp_t         st_q[$];
  exp_t         wd_q[$];
  exp_t         e_st, e_wd;
  int           order_q[$];
  int           st_acc_cyc[$];
  int           st_acc_on_done[$];
  bit           wd_acc_on_st_done = 1'b0;
  int           busy_gap = 0;
  int           ready_busy = 0;
  logic [0:127] last_st_exp = '0;
  logic [0:31]  last_wd_exp = '0;

  // Monitor: pop and compare on done, then predict and push on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.st_done) begin
        if (st_q.size() == 0) begin
          check("st_done_unexpected", 1, 0);
        end else begin
          e_st = st_q.pop_front();
          check("st_out", bus.st_out, e_st.data);
          check("st_latency", cyc - e_st.cyc, 5);
          check("wd_out_hold", bus.wd_out, last_wd_exp);
          last_st_exp = e_st.data;
        end
      end
      if (bus.wd_done) begin
        if (wd_q.size() == 0) begin
          check("wd_done_unexpected", 1, 0);
        end else begin
          e_wd = wd_q.pop_front();
          check("wd_out", bus.wd_out, e_wd.data[0:31]);
          check("wd_latency", cyc - e_wd.cyc, 2);
          check("st_out_hold", bus.st_out, last_st_exp);
          last_wd_exp = e_wd.data[0:31];
        end
      end
      if ((st_q.size() != 0 || wd_q.size() != 0) && !bus.busy) busy_gap++;
      if (bus.busy && (bus.st_ready || bus.wd_ready)) ready_busy++;
      if (bus.st_valid && bus.st_ready) begin
        e_st.data = sub_state(bus.st_in);
        e_st.cyc  = cyc;
        st_q.push_back(e_st);
        order_q.push_back(1);
        st_acc_cyc.push_back(cyc);
        st_acc_on_done.push_back(int'(bus.st_done));
      end
      if (bus.wd_valid && bus.wd_ready) begin
        e_wd.data = {sub_word(bus.wd_in), 96'h0};
        e_wd.cyc  = cyc;
        wd_q.push_back(e_wd);
        order_q.push_back(0);
        wd_acc_on_st_done = bus.st_done;
      end
    end
  end

  task automatic drive_st(input logic [0:127] d, input bit keep);
    int k;
    bus.st_valid = 1'b1;
    bus.st_in    = d;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.st_ready) break;
    end
    if (k == 60) check("st_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) bus.st_valid = 1'b0;
  endtask

  task automatic drive_wd(input logic [0:31] d, input bit keep);
    int k;
    bus.wd_valid = 1'b1;
    bus.wd_in    = d;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.wd_ready) break;
    end
    if (k == 60) check("wd_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) bus.wd_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (st_q.size() == 0 && wd_q.size() == 0) break;
    end
    if (k == 60) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[4];
    logic [0:127] d;
    bus.st_valid = 1'b0;
    bus.wd_valid = 1'b0;
    bus.st_in    = '0;
    bus.wd_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_st_out", bus.st_out, 0);
    check("rst_wd_out", bus.wd_out, 0);
    check("rst_dones", {bus.st_done, bus.wd_done, bus.busy}, 0);
    rst_n = 1'b1;
    #1;
    check("idle_readies", {bus.st_ready, bus.wd_ready}, 2'b11);

    // Single state SubBytes with the known column vector.
    drive_st(128'hd4bf5d30d4bf5d30d4bf5d30d4bf5d30, 1'b0);
    wait_quiet();
    check("st_vector", bus.st_out, 128'h48084c0448084c0448084c0448084c04);

    // Single word SubWord; state result must be left alone.
    drive_wd(32'hcf4f3c09, 1'b0);
    wait_quiet();
    check("wd_vector", bus.wd_out, 32'h8a84eb01);
    check("st_after_word", bus.st_out, 128'h48084c0448084c0448084c0448084c04);

    // Two simultaneous pairs, both requesters held valid.
    order_q.delete();
    fork
      begin
        drive_wd(32'h53535353, 1'b1);
        drive_wd(32'($urandom), 1'b0);
      end
      begin
        drive_st('0, 1'b1);
        drive_st({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      end
    join
    wait_quiet();
`ifdef SBOX_SHARE_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif
    check("order_len", order_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < order_q.size()) check($sformatf("order_%0d", i), order_q[i], exp_order[i]);
    end

    // First pair in isolation, with spec constants.
    fork
      drive_wd(32'h53535353, 1'b0);
      drive_st('0, 1'b0);
    join
    wait_quiet();
`ifndef SBOX_SHARE_RR_EN
    check("tie_wd_value", bus.wd_out, 32'hedededed);
    check("tie_st_value", bus.st_out, {16{8'h63}});
`endif

    // Back-to-back states with valid held.
    st_acc_cyc.delete();
    st_acc_on_done.delete();
    drive_st({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    drive_st({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    drive_st({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_quiet();
    check("b2b_count", st_acc_cyc.size(), 3);
    for (int i = 1; i < 3; i++) begin
      if (i < st_acc_cyc.size()) begin
        check($sformatf("b2b_spacing_%0d", i), st_acc_cyc[i] - st_acc_cyc[i-1], 5);
        check($sformatf("b2b_on_done_%0d", i), st_acc_on_done[i], 1);
      end
    end

    // Word request raised while the state beats run.
    wd_acc_on_st_done = 1'b0;
    drive_st({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    bus.wd_valid = 1'b1;
    bus.wd_in    = 32'($urandom);
    #1;
    check("wd_ready_busy", bus.wd_ready, 0);
    drive_wd(bus.wd_in, 1'b0);
    wait_quiet();
    check("wd_on_st_done", wd_acc_on_st_done, 1);

    // Asynchronous reset at beat 2 of a state.
    drive_st({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_st_out", bus.st_out, 0);
    check("mid_rst_wd_out", bus.wd_out, 0);
    check("mid_rst_flags", {bus.st_done, bus.wd_done, bus.busy}, 0);
    st_q.delete();
    wd_q.delete();
    last_st_exp = '0;
    last_wd_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    d = {$urandom, $urandom, $urandom, $urandom};
    bus.st_valid = 1'b1;
    bus.st_in    = d;
    #1;
    check("rst_first_ready", bus.st_ready, 1);
    drive_st(d, 1'b0);
    wait_quiet();

    // Mixed random traffic.
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(1, 0) == 1) drive_st({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      else                           drive_wd(32'($urandom), 1'b0);
    end
    wait_quiet();

    check("busy_gap", busy_gap, 0);
    check("ready_while_busy", ready_busy, 0);
    check("queues_empty", st_q.size() + wd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sbox_share_ctrl.md
# sbox_share_ctrl

Time-multiplexed S-box scheduler for the AES core. It owns a bank of four `sbox` instances and shares them between two requesters: the cipher round datapath, which needs a full 128-bit SubBytes, and the key expansion, which needs a 32-bit SubWord. A full state is processed one 32-bit column per cycle over four beats, replacing the 16-instance combinational `sub_bytes` path with a 4-instance sequenced one.

## Interface
- No parameters. The bank width of 4 S-boxes is fixed.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `st_valid` in 1: state SubBytes request.
- `st_ready` out 1: state request accepted when `st_valid & st_ready` at a rising edge.
- `st_in` in [0:127]: state. Byte 0 is `[0:7]`; column k is `[32k:32k+31]`.
- `st_done` out 1: one-cycle pulse; `st_out` is valid.
- `st_out` out [0:127]: substituted state. Held until the next state completion.
- `wd_valid` in 1: key-expansion SubWord request.
- `wd_ready` out 1: word request accepted when `wd_valid & wd_ready`.
- `wd_in` in [0:31]: word.
- `wd_done` out 1: one-cycle pulse; `wd_out` is valid.
- `wd_out` out [0:31]: substituted word. Held until the next word completion.
- `busy` out 1: high in any non-IDLE state.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - ST_BEAT: 2-bit beat counter `beat` runs 0..3.
  - WORD: single cycle.
- IDLE grant logic (combinational):
  - Only `st_valid` set: `st_ready`=1.
  - Only `wd_valid` set: `wd_ready`=1.
  - Both set: the arbitration winner's ready=1 and the loser's ready=0.
  - Outside IDLE: both readies are 0.
  - Ready may depend on the other requester's valid. Ready never depends on its own valid.
- State accept:
  - Capture `st_in` into an internal register.
  - Go to ST_BEAT with `beat`=0.
- ST_BEAT:
  - Bank inputs are column `beat` of the captured state.
  - At each edge, the bank result is written into column `beat` of `st_out`, and `beat` increments.
  - At `beat`=3, go to IDLE and register `st_done`=1 for the following cycle.
  - `st_out` is updated column by column during the operation. Consumers sample it only on `st_done`.
- Word accept:
  - Capture `wd_in`.
  - Go to WORD.
- WORD:
  - Bank inputs are the captured word.
  - At the next edge, write `wd_out`, pulse `wd_done`, and return to IDLE.
- Back-to-back: the cycle in which `st_done` or `wd_done` is high is an IDLE cycle, so a new request may be accepted in that same cycle.
- Reset (asynchronous, including mid-operation):
  - FSM returns to IDLE and `beat`=0.
  - All outputs clear to 0: `st_out`, `wd_out`, `st_done`, `wd_done`, `busy`.
  - The in-flight request is discarded and no done pulse is issued.
- Inputs are don't-care when valid=0 or ready=0. Dropping valid while ready is low is legal.

## Timing
- State latency: accept edge E0, bank active in cycles E0..E3, `st_done` high in the cycle after E4. That is 4 clocks from accept to done.
- Word latency: accept at E0, `wd_done` high in the cycle after E1. That is 1 clock.
- Throughput: one state per 5 cycles, or one word per 2 cycles. Done cycles overlap with the next accept.
- The critical path is one mux feeding into an `sbox`, then into a register.

## Configuration
- `SBOX_SHARE_RR_EN` defined:
  - On ties, the requester not served last wins.
  - A `last_grant` flop updates on every accept and resets to "state", so the word wins the first tie.
- `SBOX_SHARE_RR_EN` undefined:
  - Fixed priority: the word always wins ties.
  - The state can starve if `wd_valid` is held continuously. This is acceptable because the key schedule is bounded.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ST_BEAT at `beat`=2. Required: all outputs are 0 immediately, with no `st_done` after release. The next state request is accepted in the first cycle after release.
- **State SubBytes:** `st_in`=128'hd4bf5d30 repeated 4×. Required: `st_done` exactly 4 clocks after accept, with `st_out`=128'h48084c04 repeated 4×.
- **Word SubWord:** `wd_in`=32'hcf4f3c09. Required: `wd_done` 1 clock after accept, with `wd_out`=32'h8a84eb01. `st_out` is unchanged.
- **Simultaneous requests:**
  - Both valid in IDLE, `st_in`=128'h00…00 and `wd_in`=32'h53535353.
  - Required, both builds: word served first (`wd_out`=32'hedededed), then state (`st_out` all bytes 8'h63).
  - Required, `SBOX_SHARE_RR_EN` build only: a second simultaneous pair is served state first.
- **Back-to-back:** hold `st_valid`=1 for 3 states. Required: accepts coincide with the `st_done` cycles, at exactly 5-cycle spacing, and `busy` never drops between states.
- **Ready during busy:** assert `wd_valid` during ST_BEAT. Required: `wd_ready`=0 until IDLE, with the word accepted in the `st_done` cycle.
